bcd_down_counter_n: RTL and testbench
=====================================

// Module: bcd_down_counter_n
// PURPOSE
//  Loadable N-digit BCD countdown timer/counter, the decrementing counterpart of the BCD up-counter.
//  Counts a preset quantity (e.g. bottles left per crate, seconds left in a fill phase) down to zero.
//  Emits a one-cycle done pulse on reaching zero and can auto-reload the last preset.
//  Feeds the display path (d) and the bottling control FSM (zero/done).
// PARAMETERS
//  N  2  number of BCD digits; d is 4*N bits, digit i at [4i+3:4i]
// PORTS
//  clk         in   1    system clock, all state updates on posedge
//  reset       in   1    asynchronous, active-high reset
//  load        in   1    capture load_value as new preset and count value
//  load_value  in   4N   BCD preset
//  en          in   1    decrement strobe, one BCD step per cycle high
//  reload      in   1    1 = on reaching zero, restart from stored preset
//  d           out  4N   current BCD count (registered)
//  zero        out  1    d == 0 (state DONE or IDLE)
//  running     out  1    state == RUN
//  done        out  1    registered one-cycle pulse: a decrement produced 0
// BEHAVIOUR
//  Interface: one clock; reset is asynchronous and active-high.
//  Reset (any time, including mid-count): d=0, preset=0, state=IDLE, done=0; running=0, zero=1.
//  States: IDLE (post-reset), RUN (counting), DONE (reached zero, holding).
//  Load sanitising: each load_value digit >9 is clamped to 9 before use (0xA5 -> 0x95).
//  load=1 (any state): preset<=d<=sanitised value; next state RUN if value!=0, else DONE.
//   A load of 0 does not pulse done.
//  load has priority over en in the same cycle; that cycle's en is discarded.
//  RUN, en=1, d>1: d <= d-1 in BCD; borrow ripples digit to digit (0x10 -> 0x09, 0x100 -> 0x099).
//  RUN, en=1, d==1: done=1 next cycle.
//   reload=0: d<=0, state DONE.
//   reload=1: d<=preset, state stays RUN.
//   d never shows 0 in reload mode, unless preset==1 with reload=1 (then d stays 1, done pulses every en).
//  RUN, en=0: hold.
//  IDLE/DONE, en=1: ignored. No wrap to 99..9, no done pulse.
//  Latency: d, done and running reflect a load/en on the clock edge following it; zero is combinational from d.
//  done is high exactly one cycle per zero-crossing. Back-to-back crossings in reload mode give separate pulses.
//  reload is sampled only on the decrement that crosses zero; changing it at other times has no effect.
//  Width rule: count never exceeds the 10^N-1 preset; no binary intermediate, digit-serial borrow chain only.
// STRUCTURE
//  bcd_pkg (shared):
//   typedef logic [3:0] bcd_digit_t;
//   localparam bcd_digit_t BCD_MAX = 4'd9;
//   typedef enum logic [1:0] {CNT_IDLE, CNT_RUN, CNT_DONE} bcd_cnt_state_t;
//   function bcd_clamp(bcd_digit_t) -> bcd_digit_t.
//  Sub-module bcd_subtractor: one-digit combinational subtract.
//   Ports: lhs, borrow_in, diff, borrow_out.
//   0 - 1 = 9 with borrow_out=1. Mirrors the BCD adder.
//  Top level: generate loop of N bcd_subtractor instances, borrow chain seeded with 1,
//   plus the state register, d register, preset register and done flop.
// TESTING
//  1. reset; load 0x25; 7 cycles en=1 -> d=0x18, running=1, done never high.
//  2. load 0x10; 1 cycle en -> d=0x09 (cross-digit borrow); N=3: load 0x100, 1 en -> d=0x099.
//  3. load 0x03, reload=0; 5 cycles en -> d=02,01,00,00,00.
//     done high exactly 1 cycle after 01->00; state DONE, zero=1.
//  4. load 0x02, reload=1; 5 cycles en -> d=01,02,01,02,01.
//     done pulses twice, 1 cycle each; running stays 1.
//  5. load=1 with en=1, load_value=0x40 while d=0x12 -> d=0x40 (en discarded).
//     Then load 0xA5 -> d=0x95. Then load 0x00 -> DONE, zero=1, no done pulse.
//  6. load 0x50, 3 en, assert reset asynchronously mid-cycle -> d=0x00, running=0, done=0 immediately.
//     After release, en ignored until next load.

Source files
------------

// File: rtl/bcd_pkg.sv
// Shared BCD types, constants and the digit clamp helper.
package bcd_pkg;

    typedef logic [3:0] bcd_digit_t;

    localparam bcd_digit_t BCD_MAX = 4'd9;

    typedef enum logic [1:0] {
        CNT_IDLE,
        CNT_RUN,
        CNT_DONE
    } bcd_cnt_state_t;

    // Force a non-decimal nibble (A..F) down to 9.
    function automatic bcd_digit_t bcd_clamp(input bcd_digit_t v);
        return (v > BCD_MAX) ? BCD_MAX : v;
    endfunction

endpackage

// File: rtl/bcd_subtractor.sv
// One-digit combinational BCD subtract of a single borrow: diff = lhs - borrow_in.
module bcd_subtractor
    import bcd_pkg::*;
(
    input  bcd_digit_t lhs,
    input  logic       borrow_in,
    output bcd_digit_t diff,
    output logic       borrow_out
);

    // 0 - 1 wraps to 9 and propagates the borrow to the next digit.
    always_comb begin
        borrow_out = borrow_in && (lhs == 4'd0);
        if (borrow_out) begin
            diff = BCD_MAX;
        end else begin
            diff = lhs - {3'b000, borrow_in};
        end
    end

endmodule

// File: rtl/bcd_down_counter_n.sv
// Loadable N-digit BCD down-counter with done pulse and optional auto-reload.
module bcd_down_counter_n
    import bcd_pkg::*;
#(
    parameter int unsigned N = 2
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           load,
    input  logic [4*N-1:0] load_value,
    input  logic           en,
    input  logic           reload,
    output logic [4*N-1:0] d,
    output logic           zero,
    output logic           running,
    output logic           done
);

    localparam logic [4*N-1:0] COUNT_ONE  = {{(4*N-1){1'b0}}, 1'b1};
    localparam logic [4*N-1:0] COUNT_ZERO = '0;

    bcd_cnt_state_t state;
    logic [4*N-1:0] preset;
    logic [4*N-1:0] load_clean;
    logic [4*N-1:0] d_dec;
    logic [N:0]     borrow;

    // Clamp every incoming digit to 0..9 so the count stays valid BCD.
    always_comb begin
        load_clean = '0;
        for (int i = 0; i < int'(N); i++) begin
            load_clean[4*i +: 4] = bcd_clamp(load_value[4*i +: 4]);
        end
    end

    // Digit-serial borrow chain, seeded with 1 to subtract one from the whole count.
    assign borrow[0] = 1'b1;

    for (genvar g = 0; g < int'(N); g++) begin : g_digit
        bcd_subtractor u_sub (
            .lhs        (d[4*g +: 4]),
            .borrow_in  (borrow[g]),
            .diff       (d_dec[4*g +: 4]),
            .borrow_out (borrow[g+1])
        );
    end

    // Counter FSM: state, count, preset and the one-cycle done pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= CNT_IDLE;
            d      <= COUNT_ZERO;
            preset <= COUNT_ZERO;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            if (load) begin
                // Load wins over en; a zero preset goes straight to DONE without a pulse.
                preset <= load_clean;
                d      <= load_clean;
                state  <= (load_clean != COUNT_ZERO) ? CNT_RUN : CNT_DONE;
            end else if ((state == CNT_RUN) && en) begin
                if (d == COUNT_ONE) begin
                    done <= 1'b1;
                    if (reload) begin
                        d <= preset;
                    end else begin
                        d     <= COUNT_ZERO;
                        state <= CNT_DONE;
                    end
                end else begin
                    d <= d_dec;
                end
            end
        end
    end

    assign zero    = (d == COUNT_ZERO);
    assign running = (state == CNT_RUN);

endmodule

// File: tb/tb_bcd_down_counter_n.sv
// Scoreboard bench for bcd_down_counter_n: driver queues expected outputs, monitor compares.
module tb_bcd_down_counter_n;

    logic       clk = 1'b0;
    logic       reset;
    logic       load;
    logic [7:0] load_value;
    logic       en;
    logic       reload;
    logic [7:0] d;
    logic       zero;
    logic       running;
    logic       done;

    // Second instance for the three-digit borrow case.
    logic        load3;
    logic [11:0] load_value3;
    logic        en3;
    logic [11:0] d3;
    logic        zero3;
    logic        running3;
    logic        done3;

    int checks   = 0;
    int failures = 0;
    int step_id  = 0;

    typedef struct {
        int         id;
        logic [7:0] d;
        logic       zero;
        logic       running;
        logic       done;
    } exp_t;

    exp_t sb[$];

    bcd_down_counter_n #(.N(2)) dut (
        .clk        (clk),
        .reset      (reset),
        .load       (load),
        .load_value (load_value),
        .en         (en),
        .reload     (reload),
        .d          (d),
        .zero       (zero),
        .running    (running),
        .done       (done)
    );

    bcd_down_counter_n #(.N(3)) dut3 (
        .clk        (clk),
        .reset      (reset),
        .load       (load3),
        .load_value (load_value3),
        .en         (en3),
        .reload     (1'b0),
        .d          (d3),
        .zero       (zero3),
        .running    (running3),
        .done       (done3)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=%h want=%h", name, got, want);
        end
    endtask

    // Drive one cycle of inputs at the falling edge and queue what the next rising edge must show.
    task automatic step(input logic ld, input logic [7:0] lv, input logic e, input logic rl,
                        input logic [7:0] ed, input logic ez, input logic er, input logic edn);
        exp_t x;
        @(negedge clk);
        load       = ld;
        load_value = lv;
        en         = e;
        reload     = rl;
        step_id++;
        x.id      = step_id;
        x.d       = ed;
        x.zero    = ez;
        x.running = er;
        x.done    = edn;
        sb.push_back(x);
    endtask

    // Monitor: after each rising edge, compare DUT outputs against the oldest queued expectation.
    always @(posedge clk) begin
        exp_t x;
        #1;
        if (sb.size() > 0) begin
            x = sb.pop_front();
            checks++;
            if ({d, zero, running, done} !== {x.d, x.zero, x.running, x.done}) begin
                failures++;
                $display("FAIL step%0d got d=%h z=%b r=%b done=%b want d=%h z=%b r=%b done=%b",
                         x.id, d, zero, running, done, x.d, x.zero, x.running, x.done);
            end
        end
    end

    initial begin
        #20000;
        $display("FAIL watchdog timeout");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "timeout");
    end

    initial begin
        reset       = 1'b1;
        load        = 1'b0;
        load_value  = 8'h00;
        en          = 1'b0;
        reload      = 1'b0;
        load3       = 1'b0;
        load_value3 = 12'h000;
        en3         = 1'b0;

        #12;
        check("reset_d", 32'(d), 32'h00);
        check("reset_flags", 32'({zero, running, done}), 32'b100);

        @(negedge clk);
        reset = 1'b0;

        // Three-digit cross-digit borrow: 100 -> 099.
        @(negedge clk);
        load3       = 1'b1;
        load_value3 = 12'h100;
        @(negedge clk);
        load3 = 1'b0;
        en3   = 1'b1;
        check("n3_load", 32'(d3), 32'h100);
        @(negedge clk);
        en3 = 1'b0;
        check("n3_borrow", 32'(d3), 32'h099);
        check("n3_flags", 32'({zero3, running3, done3}), 32'b010);

        //   ld    lv     en    rl    d      z     r     done
        // Test 1: load 25, seven decrements.
        step(1'b1, 8'h25, 1'b0, 1'b0, 8'h25, 1'b0, 1'b1, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0, 8'h24, 1'b0, 1'b1, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0, 8'h23, 1'b0, 1'b1, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0, 8'h22, 1'b0, 1'b1, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0, 8'h21, 1'b0, 1'b1, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0, 8'h20, 1'b0, 1'b1, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0, 8'h19, 1'b0, 1'b1, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0, 8'h18, 1'b0, 1'b1, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0, 8'h18, 1'b0, 1'b1, 1'b0);
        // Test 2: 10 -> 09.
        step(1'b1, 8'h10, 1'b0, 1'b0, 8'h10, 1'b0, 1'b1, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0, 8'h09, 1'b0, 1'b1, 1'b0);
        // Test 3: count to zero without reload, then en ignored in DONE.
        step(1'b1, 8'h03, 1'b0, 1'b0, 8'h03, 1'b0, 1'b1, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0, 8'h02, 1'b0, 1'b1, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0, 8'h01, 1'b0, 1'b1, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
        step(1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        // Test 4: auto-reload of 02.
        step(1'b1, 8'h02, 1'b0, 1'b1, 8'h02, 1'b0, 1'b1, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b1, 8'h01, 1'b0, 1'b1, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b1, 8'h02, 1'b0, 1'b1, 1'b1);
        step(1'b0, 8'h00, 1'b1, 1'b1, 8'h01, 1'b0, 1'b1, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b1, 8'h02, 1'b0, 1'b1, 1'b1);
        step(1'b0, 8'h00, 1'b1, 1'b1, 8'h01, 1'b0, 1'b1, 1'b0);
        // Preset 1 with reload: d stays 1, done on every en.
        step(1'b1, 8'h01, 1'b0, 1'b1, 8'h01, 1'b0, 1'b1, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b1, 8'h01, 1'b0, 1'b1, 1'b1);
        step(1'b0, 8'h00, 1'b1, 1'b1, 8'h01, 1'b0, 1'b1, 1'b1);
        step(1'b0, 8'h00, 1'b0, 1'b1, 8'h01, 1'b0, 1'b1, 1'b0);
        // reload only matters on the crossing decrement.
        step(1'b1, 8'h03, 1'b0, 1'b1, 8'h03, 1'b0, 1'b1, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b1, 8'h02, 1'b0, 1'b1, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0, 8'h01, 1'b0, 1'b1, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b1, 8'h03, 1'b0, 1'b1, 1'b1);
        // Test 5: load beats en, digit clamping, load of zero.
        step(1'b1, 8'h12, 1'b0, 1'b0, 8'h12, 1'b0, 1'b1, 1'b0);
        step(1'b1, 8'h40, 1'b1, 1'b0, 8'h40, 1'b0, 1'b1, 1'b0);
        step(1'b1, 8'hA5, 1'b0, 1'b0, 8'h95, 1'b0, 1'b1, 1'b0);
        step(1'b1, 8'hFF, 1'b0, 1'b0, 8'h99, 1'b0, 1'b1, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0, 8'h98, 1'b0, 1'b1, 1'b0);
        step(1'b1, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        // Test 6: load 50, three decrements, then asynchronous reset mid-cycle.
        step(1'b1, 8'h50, 1'b0, 1'b0, 8'h50, 1'b0, 1'b1, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0, 8'h49, 1'b0, 1'b1, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0, 8'h48, 1'b0, 1'b1, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0, 8'h47, 1'b0, 1'b1, 1'b0);
        @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        check("async_reset_d", 32'(d), 32'h00);
        check("async_reset_flags", 32'({zero, running, done}), 32'b100);
        @(negedge clk);
        reset = 1'b0;
        // IDLE ignores en until the next load.
        step(1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        step(1'b1, 8'h07, 1'b0, 1'b0, 8'h07, 1'b0, 1'b1, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0, 8'h06, 1'b0, 1'b1, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0, 8'h06, 1'b0, 1'b1, 1'b0);

        @(negedge clk);
        @(negedge clk);
        check("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
